// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, valid/ready byte handshake.
// Optional even-parity bit between D7 and stop when UART_TX_PARITY_EN is defined.
// All outputs are registered; tx_ready does not depend combinationally on tx_valid.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic            r_tx;
   logic            r_busy;
   logic            r_done;
   logic            r_ready;

   state_t          w_state;
   logic [CW-1:0]   w_cnt;
   logic [2:0]      w_idx;
   logic [7:0]      w_shift;
   logic            w_tx;
   logic            w_bit_end;

`ifdef UART_TX_PARITY_EN
   logic            r_par;
   logic            w_par;
`endif

   assign w_bit_end = (r_cnt == '0);

   // Next-state, bit timer, shift register and next line level
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idx   = r_idx;
      w_shift = r_shift;
      w_tx    = r_tx;
`ifdef UART_TX_PARITY_EN
      w_par   = r_par;
`endif
      case (r_state)
         IDLE: begin
            w_tx = 1'b1;
            if (tx_valid && r_ready) begin
               w_state = START;
               w_cnt   = BIT_LOAD;
               w_idx   = 3'd0;
               w_shift = tx_data;
               w_tx    = 1'b0;
`ifdef UART_TX_PARITY_EN
               w_par   = ^tx_data;
`endif
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state = DATA;
               w_cnt   = BIT_LOAD;
               w_tx    = r_shift[0];
            end else begin
               w_cnt   = r_cnt - CW'(1);
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_cnt = BIT_LOAD;
               if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state = PARITY;
                  w_tx    = r_par;
`else
                  w_state = STOP;
                  w_tx    = 1'b1;
`endif
               end else begin
                  w_idx   = r_idx + 3'd1;
                  w_shift = r_shift >> 1;
                  w_tx    = r_shift[1];
               end
            end else begin
               w_cnt = r_cnt - CW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_bit_end) begin
               w_state = STOP;
               w_cnt   = BIT_LOAD;
               w_tx    = 1'b1;
            end else begin
               w_cnt   = r_cnt - CW'(1);
            end
         end
`endif
         STOP: begin
            w_tx = 1'b1;
            if (w_bit_end) begin
               w_state = IDLE;
            end else begin
               w_cnt   = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state = IDLE;
            w_tx    = 1'b1;
         end
      endcase
   end

   // State, datapath and registered outputs; done is flagged for the last stop-bit cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_shift <= w_shift;
         r_tx    <= w_tx;
         r_busy  <= (w_state != IDLE);
         r_done  <= (w_state == STOP) && (w_cnt == '0);
         r_ready <= (w_state == IDLE);
`ifdef UART_TX_PARITY_EN
         r_par   <= w_par;
`endif
      end
   end

   assign tx       = r_tx;
   assign tx_busy  = r_busy;
   assign tx_done  = r_done;
   assign tx_ready = r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (CLKS_PER_BIT=4 main instance,
// CLKS_PER_BIT=2 minimum-timing instance). Honours UART_TX_PARITY_EN.
module tb_uart_tx;

   localparam int unsigned C  = 4;
   localparam int unsigned C2 = 2;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NB = 11;
`else
   localparam int unsigned NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx, tx_busy, tx_done;
   logic [7:0] tx_data2;
   logic       tx_valid2;
   logic       tx_ready2, tx2, tx_busy2, tx_done2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   uart_tx #(.CLKS_PER_BIT(C2)) dut2 (
      .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
      .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
   );

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;   // {stop, D7..D0, start}, written out by hand
      logic       par;    // even parity of data, by hand
      logic       hold;   // keep tx_valid high into the next frame
      logic [7:0] chg;    // value driven on tx_data while the frame is busy
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference line pattern from the framing rules: start 0, data LSB first, [parity], stop 1
   function automatic logic [10:0] model_line(input logic [7:0] d);
      logic [10:0] l;
      int ones;
      l = '0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         l[i+1] = ((int'(d) >> i) % 2) == 1;
         ones += (int'(d) >> i) % 2;
      end
`ifdef UART_TX_PARITY_EN
      l[9]  = (ones % 2) == 1;
      l[10] = 1'b1;
`else
      l[9]  = 1'b1;
`endif
      return l;
   endfunction

   function automatic logic [10:0] tbl_line(input vec_t v);
`ifdef UART_TX_PARITY_EN
      return {1'b1, v.par, v.line[8:0]};
`else
      return {1'b0, v.line};
`endif
   endfunction

   // Send one byte on the C=4 instance and check every cycle of the frame plus the idle cycle after
   task automatic send4(input logic [7:0] d, input logic [10:0] exp, input logic hold,
                        input logic [7:0] chg, input string tag);
      int n;
      int flen;
      n = 0;
      flen = int'(NB * C);
      while (!tx_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_ready_wait"}, 32'(tx_ready), 32'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) tx_valid = 1'b0;
      tx_data = chg;
      for (int c = 0; c < flen; c++) begin
         chk({tag, "_tx"},    32'(tx),      32'(exp[c / int'(C)]));
         chk({tag, "_busy"},  32'(tx_busy), 32'd1);
         chk({tag, "_ready"}, 32'(tx_ready), 32'd0);
         chk({tag, "_done"},  32'(tx_done), 32'(c == flen - 1));
         if (c < flen - 1) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      chk({tag, "_idle_tx"},    32'(tx),       32'd1);
      chk({tag, "_idle_ready"}, 32'(tx_ready), 32'd1);
      chk({tag, "_idle_busy"},  32'(tx_busy),  32'd0);
      chk({tag, "_idle_done"},  32'(tx_done),  32'd0);
   endtask

   vec_t tbl[7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rb;
      logic [10:0] e2;
      logic        rh;

      tbl[0] = '{8'hA5, 10'b1_10100101_0, 1'b0, 1'b0, 8'hA5};
      tbl[1] = '{8'h00, 10'b1_00000000_0, 1'b0, 1'b1, 8'h00};
      tbl[2] = '{8'hFF, 10'b1_11111111_0, 1'b0, 1'b0, 8'hFF};
      tbl[3] = '{8'h3C, 10'b1_00111100_0, 1'b0, 1'b0, 8'hC3};
      tbl[4] = '{8'h81, 10'b1_10000001_0, 1'b0, 1'b0, 8'h81};
      tbl[5] = '{8'h07, 10'b1_00000111_0, 1'b1, 1'b0, 8'h07};
      tbl[6] = '{8'h03, 10'b1_00000011_0, 1'b0, 1'b0, 8'h03};

      rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      tx_valid2 = 1'b0; tx_data2 = 8'h00;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_tx",    32'(tx),       32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy",  32'(tx_busy),  32'd0);
      chk("rst_done",  32'(tx_done),  32'd0);
      @(posedge clk); #1;

      // Table frames: 0xA5, back-to-back 0x00/0xFF, mid-frame data change, parity bytes
      for (int i = 0; i < 7; i++) begin
         send4(tbl[i].data, tbl_line(tbl[i]), tbl[i].hold, tbl[i].chg, $sformatf("tbl%0d", i));
      end
      tx_valid = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of D4 of 0x55: abort, no done pulse
      tx_data = 8'h55; tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      for (int c = 0; c < int'(5 * C + 1); c++) begin
         chk("abort_pre_done", 32'(tx_done), 32'd0);
         @(posedge clk); #1;
      end
      chk("abort_in_frame", 32'(tx_busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_tx",    32'(tx),       32'd1);
      chk("abort_busy",  32'(tx_busy),  32'd0);
      chk("abort_ready", 32'(tx_ready), 32'd1);
      chk("abort_done",  32'(tx_done),  32'd0);
      for (int c = 0; c < int'(4 * C); c++) begin
         @(posedge clk); #1;
         chk("abort_quiet_tx",   32'(tx),      32'd1);
         chk("abort_quiet_done", 32'(tx_done), 32'd0);
      end
      send4(8'h81, model_line(8'h81), 1'b0, 8'h81, "after_abort");

      // Random bytes, random back-to-back and random bus noise during the frame
      for (int k = 0; k < 10; k++) begin
         rb = 8'($urandom);
         rh = 1'($urandom);
         send4(rb, model_line(rb), rh, 8'($urandom), $sformatf("rnd%0d", k));
      end
      tx_valid = 1'b0;
      @(posedge clk); #1;

      // Minimum CLKS_PER_BIT: 0x01, each bit exactly two cycles
      e2 = model_line(8'h01);
      tx_data2 = 8'h01; tx_valid2 = 1'b1;
      @(posedge clk); #1;
      tx_valid2 = 1'b0;
      for (int c = 0; c < int'(NB * C2); c++) begin
         chk("min_tx",   32'(tx2),      32'(e2[c / int'(C2)]));
         chk("min_busy", 32'(tx_busy2), 32'd1);
         chk("min_done", 32'(tx_done2), 32'(c == int'(NB * C2) - 1));
         if (c < int'(NB * C2) - 1) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      chk("min_idle_ready", 32'(tx_ready2), 32'd1);
      chk("min_idle_tx",    32'(tx2),       32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tx_data  input  8  byte to send; sampled only at handshake.
REQ-005 tx_valid  input  1  producer has a byte on tx_data.
REQ-006 tx_ready  output  1  block can accept a byte this cycle.
REQ-007 tx  output  1  serial line, idle high.
REQ-008 tx_busy  output  1  frame in progress.
REQ-009 tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-010 Frame SHALL be 8N1, LSB first: start bit (0), D0..D7, stop bit (1).
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, plus PARITY when enabled (REQ-024).
REQ-012 Handshake: a byte SHALL be accepted in any cycle with tx_valid=1 and tx_ready=1; tx_data is latched into a shift register in that cycle.
REQ-013 tx_ready SHALL be 1 only in IDLE and 0 in all other states (registered, no combinational path from tx_valid).
REQ-014 Latency: tx SHALL go low on the cycle after acceptance; IDLE->START transition occurs on the acceptance edge.
REQ-015 Each bit SHALL hold on tx for exactly CLKS_PER_BIT cycles, timed by a down-counter of width clog2(CLKS_PER_BIT), reloaded at every bit boundary.
REQ-016 DATA SHALL use a 3-bit index counting 0..7; DATA->STOP (or PARITY) after bit 7 completes, no wrap.
REQ-017 tx_done SHALL pulse high for exactly one cycle, the last cycle of the stop bit; the FSM enters IDLE on the following edge.
REQ-018 tx_busy SHALL be 1 in every state except IDLE.
REQ-019 Total frame SHALL occupy 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity) from first start-bit cycle to last stop-bit cycle.
REQ-020 Back-to-back: with tx_valid held high, the next byte SHALL be accepted in the single IDLE cycle after tx_done, giving exactly one idle-high cycle between frames.
REQ-021 Changes to tx_data or tx_valid while busy SHALL have no effect on the current frame.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, tx=1, tx_busy=0, tx_done=0, tx_ready=1, counters and shift register cleared, on the next cycle.
REQ-023 rst asserted mid-frame SHALL abort the frame; tx returns high the cycle after, the partial byte is discarded, and tx_done is not pulsed.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of D0..D7) SHALL be sent for CLKS_PER_BIT cycles between D7 and stop; frame is 11 bits.
REQ-025 Macro UART_TX_PARITY_EN undefined: no PARITY state or logic SHALL exist; DATA goes straight to STOP; frame is 10 bits.

Verification
REQ-026 CLKS_PER_BIT=4, send 0xA5 -> tx samples at bit centres 0,1,0,1,0,0,1,0,1,1; tx_done at cycle 40 after start; tx_ready back to 1 next cycle.
REQ-027 tx_valid held high with 0x00 then 0xFF -> two frames separated by exactly one tx=1 idle cycle; second frame data bits all 1.
REQ-028 Change tx_data from 0x3C to 0xC3 mid-frame -> transmitted byte remains 0x3C.
REQ-029 rst pulsed during D4 of 0x55 -> tx=1, tx_busy=0, tx_ready=1 the next cycle; no tx_done pulse; next send of 0x81 correct.
REQ-030 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame length 44 cycles at CLKS_PER_BIT=4; send 0x03 -> parity bit 0.
REQ-031 CLKS_PER_BIT=2 (minimum), send 0x01 -> each bit lasts exactly 2 cycles; frame 20 cycles.
